// File: rtl/serial_addsub.sv
// Digit-serial two's-complement adder/subtractor: WIDTH bits, DIGIT bits per clock, LSB first.
// Optional macro SERIAL_ADDSUB_SAT_EN clamps the result to signed saturation on overflow.
module serial_addsub #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    generate
        if ((WIDTH < 2) || ((WIDTH % DIGIT) != 0)) begin : g_param_check
            $error("serial_addsub: WIDTH must be >= 2 and a multiple of DIGIT");
        end
    endgenerate

    logic [1:0]       state_reg;
    logic [CW-1:0]    cnt_reg;
    logic             carry_reg;
    logic             mode_reg;
    logic [WIDTH-1:0] a_sh_reg;
    logic [WIDTH-1:0] b_sh_reg;
    logic [WIDTH-1:0] sum_reg;
    logic [WIDTH-1:0] result_reg;
    logic             cout_reg;
    logic             ovf_reg;

    // Subtraction is A + ~B + 1: B is inverted here, the +1 comes from the initial carry.
    logic [WIDTH-1:0] b_eff;
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_binv
            assign b_eff[gi] = b[gi] ^ mode;
        end
    endgenerate

    logic [DIGIT:0]         slice;
    logic [DIGIT-1:0]       slice_sum;
    logic                   slice_carry;
    logic [WIDTH+DIGIT-1:0] sum_wide;
    logic [WIDTH-1:0]       sum_next;
    logic                   a_msb;
    logic                   bx_msb;
    logic                   ovf_next;
    logic                   cout_next;
    logic [WIDTH-1:0]       result_next;

    always_comb begin
        slice       = (DIGIT+1)'(a_sh_reg[DIGIT-1:0]) + (DIGIT+1)'(b_sh_reg[DIGIT-1:0])
                    + (DIGIT+1)'(carry_reg);
        slice_sum   = slice[DIGIT-1:0];
        slice_carry = slice[DIGIT];
        sum_wide    = {slice_sum, sum_reg};
        sum_next    = sum_wide[WIDTH+DIGIT-1:DIGIT];
        // On the last digit the low slice of each shift register holds the operand MSBs.
        a_msb       = a_sh_reg[DIGIT-1];
        bx_msb      = b_sh_reg[DIGIT-1];
        ovf_next    = (a_msb == bx_msb) && (slice_sum[DIGIT-1] != a_msb);
        cout_next   = slice_carry ^ mode_reg;
`ifdef SERIAL_ADDSUB_SAT_EN
        if (ovf_next)
            result_next = a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        else
            result_next = sum_next;
`else
        result_next = sum_next;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= S_IDLE;
            cnt_reg    <= '0;
            carry_reg  <= 1'b0;
            mode_reg   <= 1'b0;
            a_sh_reg   <= '0;
            b_sh_reg   <= '0;
            sum_reg    <= '0;
            result_reg <= '0;
            cout_reg   <= 1'b0;
            ovf_reg    <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        a_sh_reg  <= a;
                        b_sh_reg  <= b_eff;
                        carry_reg <= mode;
                        mode_reg  <= mode;
                        cnt_reg   <= '0;
                        sum_reg   <= '0;
                        state_reg <= S_RUN;
                    end else begin
                        state_reg <= S_IDLE;
                    end
                end
                S_RUN: begin
                    a_sh_reg  <= a_sh_reg >> DIGIT;
                    b_sh_reg  <= b_sh_reg >> DIGIT;
                    carry_reg <= slice_carry;
                    sum_reg   <= sum_next;
                    cnt_reg   <= cnt_reg + 1'b1;
                    if (cnt_reg == LAST) begin
                        result_reg <= result_next;
                        cout_reg   <= cout_next;
                        ovf_reg    <= ovf_next;
                        state_reg  <= S_DONE;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign busy   = (state_reg == S_RUN);
    assign done   = (state_reg == S_DONE);
    assign result = result_reg;
    assign cout   = cout_reg;
    assign ovf    = ovf_reg;

endmodule
